// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: default widths, timing parameters,
// FSM state encoding and the counter width used for wait and burst tracking.
package sram_arbiter_pkg;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_LATENCY        = 2;
    localparam int DEF_MAX_DATA_BURST = 4;

    // LATENCY and MAX_DATA_BURST are both limited to 1..15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] to_cnt(input int v);
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the fetch port, the data port and the single-ported SRAM.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface sram_arbiter_if
    import sram_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_rd_req;
    logic              dm_wr_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              freeze;

    modport slave (
        input  if_req, if_addr, dm_rd_req, dm_wr_req, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, freeze
    );

    modport master (
        output if_req, if_addr, dm_rd_req, dm_wr_req, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, freeze
    );

endinterface

// File: rtl/sram_arbiter_wait_counter.sv
// Access wait timer: loads at grant, counts down once per busy cycle and
// flags the final access cycle when it reaches zero.
module sram_arbiter_wait_counter
    import sram_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one SRAM with a
// fixed access latency; data wins unless a fetch has waited out a full burst.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | no access; arbitrate pending requests
// ST_BUSY_IF | fetch access in progress, mem_en held high
// ST_BUSY_DM | data read/write in progress, mem_en held high
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int LATENCY        = DEF_LATENCY,
    parameter int MAX_DATA_BURST = DEF_MAX_DATA_BURST
) (
    input logic           clk,
    input logic           rst,
    sram_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              we_q;
    logic              if_ready_q;
    logic              dm_ready_q;
    logic [CNT_W-1:0]  burst_cnt_q;

    logic dm_req;
    logic idle_ok;
    logic if_wins;
    logic grant_if;
    logic grant_dm;
    logic wait_zero;
    logic busy;
    logic done_if;
    logic done_dm;
    logic mem_we_c;

    assign dm_req = bus.dm_rd_req | bus.dm_wr_req;

    // The ready cycle grants nothing, so a requester that is only now seeing
    // its ready is not re-granted on the line it has not yet dropped.
    assign idle_ok  = (state_q == ST_IDLE) && !if_ready_q && !dm_ready_q;
    assign if_wins  = bus.if_req && (!dm_req || burst_cnt_q == to_cnt(MAX_DATA_BURST));
    assign grant_if = idle_ok && if_wins;
    assign grant_dm = idle_ok && dm_req && !if_wins;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_dm) begin
                    state_d = ST_BUSY_DM;
                end else if (grant_if) begin
                    state_d = ST_BUSY_IF;
                end
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
                if (wait_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done_if  = 1'b0;
        done_dm  = 1'b0;
        mem_we_c = 1'b0;
        case (state_q)
            ST_BUSY_IF: begin
                busy    = 1'b1;
                done_if = wait_zero;
            end
            ST_BUSY_DM: begin
                busy     = 1'b1;
                done_dm  = wait_zero;
                mem_we_c = we_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            if_ready_q <= done_if;
            dm_ready_q <= done_dm;
            if (grant_if) begin
                addr_q <= bus.if_addr;
                we_q   <= 1'b0;
            end else if (grant_dm) begin
                addr_q  <= bus.dm_addr;
                wdata_q <= bus.dm_wdata;
                we_q    <= bus.dm_wr_req;
            end
            if (done_if) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (done_dm && !we_q) begin
                dm_rdata_q <= bus.mem_rdata;
            end
            if (!bus.if_req || grant_if) begin
                burst_cnt_q <= '0;
            end else if (grant_dm && burst_cnt_q != to_cnt(MAX_DATA_BURST)) begin
                burst_cnt_q <= burst_cnt_q + CNT_W'(1);
            end
        end
    end

    sram_arbiter_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (grant_if | grant_dm),
        .load_val_i (to_cnt(LATENCY - 1)),
        .dec_i      (busy),
        .zero_o     (wait_zero)
    );

    assign bus.mem_en    = busy;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.freeze    = (bus.if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a transaction-level model predicts every
// output each cycle, plus literal expectations for the named scenarios.
module tb_sram_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int LAT  = 2;
    localparam int MAXB = 4;

    logic clk;
    logic rst;

    sram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sram_arbiter #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .LATENCY        (LAT),
        .MAX_DATA_BURST (MAXB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: remaining busy cycles of the access in flight,
    // who owns it, and what was captured at grant.
    int          m_left = 0;
    bit          m_dm = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    bit          m_rdy_if = 0;
    bit          m_rdy_dm = 0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_dm_rdata = '0;
    int          m_burst = 0;

    task automatic m_reset();
        m_left = 0; m_dm = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        m_rdy_if = 0; m_rdy_dm = 0; m_if_rdata = '0; m_dm_rdata = '0; m_burst = 0;
    endtask

    task automatic m_step();
        bit dmr;
        bit acked;
        bit take_if;
        dmr   = bus.dm_rd_req || bus.dm_wr_req;
        acked = m_rdy_if || m_rdy_dm;
        m_rdy_if = 0;
        m_rdy_dm = 0;
        if (m_left > 0) begin
            if (m_left == 1) begin
                if (m_dm) begin
                    m_rdy_dm = 1;
                    if (!m_we) m_dm_rdata = bus.mem_rdata;
                end else begin
                    m_rdy_if = 1;
                    m_if_rdata = bus.mem_rdata;
                end
            end
            m_left--;
        end else if (!acked && (bus.if_req || dmr)) begin
            take_if = bus.if_req && (!dmr || m_burst == MAXB);
            m_left  = LAT;
            m_dm    = !take_if;
            if (take_if) begin
                m_addr  = bus.if_addr;
                m_we    = 0;
                m_burst = 0;
            end else begin
                m_addr  = bus.dm_addr;
                m_wdata = bus.dm_wdata;
                m_we    = bus.dm_wr_req;
                if (bus.if_req && m_burst < MAXB) m_burst++;
            end
        end
        if (!bus.if_req) m_burst = 0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) m_reset();
        else m_step();
    end

    always @(negedge clk) begin
        bit exp_freeze;
        exp_freeze = (bus.if_req && !m_rdy_if) || ((bus.dm_rd_req || bus.dm_wr_req) && !m_rdy_dm);
        check("mem_en",    bus.mem_en,    (m_left > 0) ? 1 : 0);
        check("mem_we",    bus.mem_we,    (m_left > 0 && m_dm && m_we) ? 1 : 0);
        check("mem_addr",  bus.mem_addr,  m_addr);
        check("mem_wdata", bus.mem_wdata, m_wdata);
        check("if_ready",  bus.if_ready,  m_rdy_if ? 1 : 0);
        check("dm_ready",  bus.dm_ready,  m_rdy_dm ? 1 : 0);
        check("if_rdata",  bus.if_rdata,  m_if_rdata);
        check("dm_rdata",  bus.dm_rdata,  m_dm_rdata);
        check("freeze",    bus.freeze,    exp_freeze ? 1 : 0);
    end

    // Address of every access, in grant order.
    logic [31:0] glog[$];
    bit prev_en = 0;
    always @(negedge clk) begin
        if (bus.mem_en && !prev_en) glog.push_back(bus.mem_addr);
        prev_en = bus.mem_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm, input bit dm, output int lat,
                              output int en_cnt, output int we_cnt);
        bit seen;
        seen = 0; lat = 0; en_cnt = 0; we_cnt = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            lat++;
            en_cnt += int'(bus.mem_en);
            we_cnt += int'(bus.mem_we);
            if (dm ? bus.dm_ready : bus.if_ready) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: ready not seen after %0d cycles, required within 30", nm, lat);
        end
    endtask

    int lat, en, we;
    logic [31:0] exp_seq[6];

    initial begin
        rst = 1'b0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_rd_req = 0; bus.dm_wr_req = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_rdata = '0;
        repeat (2) tick();
        check("rst_mem_en",   bus.mem_en,   0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_if_rdata", bus.if_rdata, 0);

        // Fetch issued together with reset release
        bus.if_addr = 32'h40; bus.mem_rdata = 32'h2010000A; bus.if_req = 1; rst = 1'b1;
        wait_ready("fetch", 0, lat, en, we);
        check("fetch_latency", lat, 3);
        check("fetch_en_cycles", en, 2);
        check("fetch_rdata", bus.if_rdata, 32'h2010000A);
        check("fetch_addr", bus.mem_addr, 32'h40);
        bus.if_req = 0;
        repeat (2) tick();

        // Write
        bus.mem_rdata = 32'h55555555;
        bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF; bus.dm_wr_req = 1;
        wait_ready("write", 1, lat, en, we);
        check("write_latency", lat, 3);
        check("write_we_cycles", we, 2);
        check("write_addr", bus.mem_addr, 32'h100);
        check("write_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check("write_dm_rdata", bus.dm_rdata, 0);
        bus.dm_wr_req = 0;
        tick();
        check("write_single_pulse", bus.dm_ready, 0);
        tick();

        // Contention: DM first, then IF
        glog.delete();
        bus.mem_rdata = 32'h11112222;
        bus.if_addr = 32'h40; bus.dm_addr = 32'h200;
        bus.if_req = 1; bus.dm_rd_req = 1;
        wait_ready("cont_dm", 1, lat, en, we);
        bus.dm_rd_req = 0;
        #1;
        check("cont_freeze_held", bus.freeze, 1);
        wait_ready("cont_if", 0, lat, en, we);
        check("cont_grants", glog.size(), 2);
        if (glog.size() >= 2) begin
            check("cont_first", glog[0], 32'h200);
            check("cont_second", glog[1], 32'h40);
        end
        check("cont_if_rdata", bus.if_rdata, 32'h11112222);
        check("cont_dm_rdata", bus.dm_rdata, 32'h11112222);
        bus.if_req = 0;
        #1;
        check("cont_freeze_released", bus.freeze, 0);
        repeat (2) tick();

        // Starvation guard
        glog.delete();
        bus.mem_rdata = 32'h33334444;
        bus.dm_addr = 32'h300; bus.if_addr = 32'h80;
        bus.dm_rd_req = 1; bus.if_req = 1;
        for (int i = 0; i < 200 && glog.size() < 6; i++) begin
            tick();
            if (bus.if_ready) bus.if_req = 0;
        end
        check("starve_grants", glog.size(), 6);
        exp_seq[0] = 32'h300; exp_seq[1] = 32'h300; exp_seq[2] = 32'h300;
        exp_seq[3] = 32'h300; exp_seq[4] = 32'h80;  exp_seq[5] = 32'h300;
        for (int i = 0; i < 6; i++) begin
            if (i < glog.size()) check($sformatf("starve_seq%0d", i), glog[i], exp_seq[i]);
        end
        // Dropping the request mid-access must not abort it
        bus.dm_rd_req = 0;
        wait_ready("starve_tail", 1, lat, en, we);
        check("starve_dm_rdata", bus.dm_rdata, 32'h33334444);
        repeat (2) tick();

        // Reset in the second busy cycle
        bus.if_addr = 32'h44; bus.mem_rdata = 32'hA5A5A5A5; bus.if_req = 1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_mem_en", bus.mem_en, 0);
        check("rst_mid_if_ready", bus.if_ready, 0);
        check("rst_mid_mem_addr", bus.mem_addr, 0);
        check("rst_mid_if_rdata", bus.if_rdata, 0);
        tick();
        check("rst_mid_no_pulse", bus.if_ready, 0);
        rst = 1'b1;
        wait_ready("rst_refetch", 0, lat, en, we);
        check("rst_refetch_latency", lat, 3);
        check("rst_refetch_rdata", bus.if_rdata, 32'hA5A5A5A5);
        bus.if_req = 0;
        repeat (2) tick();

        // Read and write both high: treated as a write
        bus.dm_addr = 32'h500; bus.dm_wdata = 32'h12345678; bus.mem_rdata = 32'h99999999;
        bus.dm_rd_req = 1; bus.dm_wr_req = 1;
        wait_ready("rdwr", 1, lat, en, we);
        check("rdwr_we_cycles", we, 2);
        check("rdwr_wdata", bus.mem_wdata, 32'h12345678);
        check("rdwr_dm_rdata", bus.dm_rdata, 0);
        bus.dm_rd_req = 0; bus.dm_wr_req = 0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, word width
- ADDR_W, 32, byte address width
- LATENCY, 2, memory cycles per access, legal range 1..15
- MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch waits, legal range 1..15
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge
- rst, in, 1, reset, asynchronous, active-low
- if_req, in, 1, instruction fetch request, level
- if_addr, in, ADDR_W, fetch address
- if_rdata, out, DATA_W, fetch data
- if_ready, out, 1, one-cycle fetch completion pulse
- dm_rd_req, in, 1, data read request, level
- dm_wr_req, in, 1, data write request, level
- dm_addr, in, ADDR_W, data address
- dm_wdata, in, DATA_W, write data
- dm_rdata, out, DATA_W, read data
- dm_ready, out, 1, one-cycle data completion pulse
- mem_en, out, 1, memory access active
- mem_we, out, 1, memory write strobe
- mem_addr, out, ADDR_W, latched address
- mem_wdata, out, DATA_W, latched write data
- mem_rdata, in, DATA_W, memory read data, valid in the last access cycle
- freeze, out, 1, pipeline stall: (if_req and not if_ready) or (dm request and not dm_ready)

Function
REQ-003 The block SHALL implement an FSM with states IDLE, BUSY_IF and BUSY_DM.
REQ-004 In IDLE with any request present, the block SHALL grant on the next edge, latch the address, write data and write flag, and enter BUSY_*.
REQ-005 Grant priority SHALL go to the data port, unless burst_cnt equals MAX_DATA_BURST and if_req is high; in that case IF wins.
REQ-006 burst_cnt SHALL increment on each DM grant while if_req is high, saturate at MAX_DATA_BURST, and clear on an IF grant or whenever if_req is low.
REQ-007 In BUSY_*, mem_en SHALL be 1, mem_addr and mem_wdata SHALL be held stable, and mem_we SHALL equal the latched write flag for all LATENCY cycles.
REQ-008 wait_cnt SHALL load LATENCY-1 at grant and decrement each BUSY cycle.
REQ-009 In the cycle where wait_cnt equals 0, the matching ready SHALL pulse for one cycle, and mem_rdata SHALL be captured into if_rdata or dm_rdata (reads only).
REQ-010 After the ready cycle, the FSM SHALL return to IDLE.
REQ-011 Request-to-ready latency SHALL be LATENCY+1 cycles.
REQ-012 There SHALL be no back-to-back grants: at least one IDLE cycle separates accesses.
REQ-013 if_rdata and dm_rdata SHALL hold their value until the next read completion on the same port.
REQ-014 If dm_rd_req and dm_wr_req are both high, the request SHALL be treated as a write.
REQ-015 Requests SHALL stay high until ready; deassertion mid-access SHALL NOT abort the access, and the access completes with a ready pulse.
REQ-016 Address or data changes during BUSY SHALL be ignored, because the values are latched at grant.
REQ-017 If a requester keeps its request high after ready, the request SHALL be treated as a new access and re-arbitrated in IDLE.
REQ-018 freeze SHALL be combinational from the requests and ready outputs.

Reset
REQ-019 When rst is low, the block SHALL immediately set state to IDLE, burst_cnt and wait_cnt to 0, mem_en, mem_we, if_ready and dm_ready to 0, and mem_addr, mem_wdata, if_rdata and dm_rdata to 0.
REQ-020 An access in flight during reset SHALL be dropped without a ready pulse.
REQ-021 The first grant SHALL be possible on the first rising edge after rst goes high.

Structure
REQ-022 A shared mem_defs package/include SHALL hold the state encodings, the default LATENCY and MAX_DATA_BURST, and DATA_W and ADDR_W.
REQ-023 The block SHALL instantiate one sub-module, wait_counter: load, decrement, zero flag.

Verification (LATENCY=2, MAX_DATA_BURST=4)
REQ-024 The bench SHALL cover these directed scenarios:
- Fetch: if_req=1, if_addr=0x40, mem_rdata=0x2010000A -> mem_en high 2 cycles; if_ready pulses 3 cycles after req; if_rdata=0x2010000A.
- Write: dm_wr_req=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_we=1 for 2 cycles at mem_addr=0x100; dm_ready pulses once; dm_rdata unchanged.
- Contention: if_req and dm_rd_req raised together -> DM served first, then IF; freeze high until if_ready.
- Starvation: dm_rd_req held high for 6 accesses with if_req high -> 4 DM grants, then 1 IF grant, then DM resumes.
- Reset mid-access: rst low in the 2nd BUSY cycle -> mem_en=0 at once, no ready pulse, state IDLE; after release, if_req=1 -> normal fetch completes.
- Read+write both high on the DM port -> write performed (mem_we=1).
